// File: rtl/seq_tx_if.sv
// Request/response bundle for the serial pattern transmitter.
// The master side drives the request fields, the slave side drives status.
interface seq_tx_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 5
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  len;
  logic [3:0]        rep;
  logic [3:0]        gap;
  logic              dout;
  logic              dvalid;
  logic              busy;
  logic              done;
  logic [2:0]        present_state;

  modport master (
    output start, data, len, rep, gap,
    input  dout, dvalid, busy, done, present_state
  );

  modport slave (
    input  start, data, len, rep, gap,
    output dout, dvalid, busy, done, present_state
  );
endinterface

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends the top len bits of a captured word
// MSB-first, repeated rep extra times with gap idle bit-times in between,
// then pulses done for one cycle. All outputs are decoded from registers.
module seq_tx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 5
) (
  input  logic   clk,
  input  logic   clr,
  seq_tx_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SHIFT = 3'b001,
    ST_GAP   = 3'b010,
    ST_DONE  = 3'b011
  } state_t;

  localparam logic [LEN_W-1:0] LP_LEN_MAX = LEN_W'(DATA_W);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_pat;
  logic [DATA_W-1:0] r_shift;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_bitcnt;
  logic [3:0]        r_rep;
  logic [3:0]        r_gap;
  logic [3:0]        r_gapcnt;

  logic              w_len_ok;
  logic              w_last_bit;
  logic              w_gap_last;

  logic              w_load;
  logic              w_shift_step;
  logic              w_reload;
  logic              w_gap_clr;
  logic              w_gap_step;

  // Qualifiers for request acceptance and frame/gap termination
  always_comb begin
    w_len_ok   = (bus.len != '0) && (bus.len <= LP_LEN_MAX);
    w_last_bit = (r_bitcnt == (r_len - LEN_W'(1)));
    w_gap_last = (r_gapcnt == (r_gap - 4'd1));
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_shift_step = 1'b0;
    w_reload     = 1'b0;
    w_gap_clr    = 1'b0;
    w_gap_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && w_len_ok) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          if (r_rep != '0) begin
            if (r_gap != '0) begin
              w_gap_clr   = 1'b1;
              w_state_nxt = ST_GAP;
            end else begin
              // Zero gap: reload in place so the next frame follows with no bubble
              w_reload = 1'b1;
            end
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_shift_step = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_gap_last) begin
          w_reload    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_gap_step = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Captured request, shift register and counters
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pat    <= '0;
      r_shift  <= '0;
      r_len    <= '0;
      r_bitcnt <= '0;
      r_rep    <= '0;
      r_gap    <= '0;
      r_gapcnt <= '0;
    end else begin
      if (w_load) begin
        r_pat    <= bus.data;
        r_shift  <= bus.data;
        r_len    <= bus.len;
        r_rep    <= bus.rep;
        r_gap    <= bus.gap;
        r_bitcnt <= '0;
        r_gapcnt <= '0;
      end
      if (w_shift_step) begin
        r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
        r_bitcnt <= r_bitcnt + LEN_W'(1);
      end
      if (w_reload) begin
        r_shift  <= r_pat;
        r_bitcnt <= '0;
        r_rep    <= r_rep - 4'd1;
      end
      if (w_gap_clr) begin
        r_gapcnt <= '0;
      end
      if (w_gap_step) begin
        r_gapcnt <= r_gapcnt + 4'd1;
      end
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    bus.dvalid        = (r_state == ST_SHIFT);
    bus.dout          = (r_state == ST_SHIFT) ? r_shift[DATA_W-1] : 1'b0;
    bus.busy          = (r_state != ST_IDLE);
    bus.done          = (r_state == ST_DONE);
    bus.present_state = r_state;
  end

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: hand-computed serial streams, lengths,
// timing, abort on clear and request filtering.
module tb_seq_tx;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errs;

  seq_tx_if #(.DATA_W(8), .LEN_W(5)) bus ();

  seq_tx #(.DATA_W(8), .LEN_W(5)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input logic [4:0] l,
                          input logic [3:0] r, input logic [3:0] g);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.data  = d;
    bus.len   = l;
    bus.rep   = r;
    bus.gap   = g;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called in the first cycle after the accepting edge; returns in the done cycle
  task automatic run_capture(output int ncyc, output logic [31:0] dseq,
                             output logic [31:0] vseq, output int nbusy,
                             output int ndet, output int nbad);
    logic [3:0] win;
    bit         fin;
    ncyc = 0; dseq = '0; vseq = '0; nbusy = 0; ndet = 0; nbad = 0;
    win = '0; fin = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      ncyc++;
      if (bus.busy) nbusy++;
      if (!bus.dvalid && bus.dout) nbad++;
      if (bus.done) begin
        fin = 1'b1;
      end else begin
        dseq = {dseq[30:0], bus.dout};
        vseq = {vseq[30:0], bus.dvalid};
        if (bus.dvalid) begin
          win = {win[2:0], bus.dout};
          if (win == 4'b1101) ndet++;
        end
        @(posedge clk); #1;
      end
    end
    if (!fin) chk("timeout_done", 0, 1);
  endtask

  initial begin
    int          ncyc, nbusy, ndet, nbad, ndone;
    logic [31:0] dseq, vseq;

    n_checks  = 0;
    n_errs    = 0;
    clr       = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.len   = '0;
    bus.rep   = '0;
    bus.gap   = '0;

    #2;
    chk("reset_outs", {bus.present_state, bus.dout, bus.dvalid, bus.busy, bus.done}, 0);
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;

    // Single 4-bit frame
    start_tx(8'hD0, 5'd4, 4'd0, 4'd0);
    chk("f4_first_state", bus.present_state, 3'b001);
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("f4_dout", dseq, 32'hD);
    chk("f4_dvalid", vseq, 32'hF);
    chk("f4_cycles", ncyc, 5);
    chk("f4_busy", nbusy, 5);
    @(posedge clk); #1;
    chk("f4_idle_after", {bus.present_state, bus.busy, bus.done}, 0);

    // Repeat with gap
    start_tx(8'hA0, 5'd3, 4'd1, 4'd2);
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("rg_dout", dseq, 32'hA5);
    chk("rg_dvalid", vseq, 32'hE7);
    chk("rg_cycles", ncyc, 9);
    chk("rg_dout_when_invalid", nbad, 0);

    // Two repeats, single-cycle gap
    start_tx(8'hA0, 5'd2, 4'd2, 4'd1);
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("r2_dout", dseq, 32'h92);
    chk("r2_dvalid", vseq, 32'hDB);
    chk("r2_cycles", ncyc, 9);

    // Full-width frame
    start_tx(8'h96, 5'd8, 4'd0, 4'd0);
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("full_dout", dseq, 32'h96);
    chk("full_cycles", ncyc, 9);

    // Illegal lengths are rejected
    start_tx(8'hFF, 5'd0, 4'd0, 4'd0);
    chk("len0_state", {bus.present_state, bus.busy, bus.dvalid, bus.done}, 0);
    @(posedge clk); #1;
    chk("len0_state2", {bus.present_state, bus.busy, bus.dvalid, bus.done}, 0);
    start_tx(8'hFF, 5'd9, 4'd0, 4'd0);
    chk("len9_state", {bus.present_state, bus.busy, bus.dvalid, bus.done}, 0);

    // Loopback into 1101 detector
    start_tx(8'hD0, 5'd4, 4'd1, 4'd0);
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("lb_stream", dseq, 32'hDD);
    chk("lb_dvalid", vseq, 32'hFF);
    chk("lb_cycles", ncyc, 9);
    chk("lb_detects", ndet, 2);

    // Clear in the 2nd SHIFT cycle aborts without done
    start_tx(8'hD0, 5'd4, 4'd0, 4'd0);
    @(posedge clk); #1;
    chk("abort_pre_state", {bus.present_state, bus.dvalid, bus.dout}, {3'b001, 1'b1, 1'b1});
    #2 clr = 1'b1;
    #1;
    chk("abort_async", {bus.present_state, bus.dout, bus.dvalid, bus.busy, bus.done}, 0);
    #3 clr = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    start_tx(8'hA0, 5'd3, 4'd0, 4'd0);
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("post_clr_dout", dseq, 32'h5);
    chk("post_clr_cycles", ncyc, 4);

    // Input changes and start while busy are ignored, including the DONE cycle
    start_tx(8'hD0, 5'd4, 4'd0, 4'd0);
    bus.start = 1'b1;
    bus.data  = 8'h00;
    bus.len   = 5'd2;
    bus.rep   = 4'd3;
    bus.gap   = 4'd1;
    run_capture(ncyc, dseq, vseq, nbusy, ndet, nbad);
    chk("busy_ign_dout", dseq, 32'hD);
    chk("busy_ign_cycles", ncyc, 5);
    @(posedge clk); #1;
    chk("done_ign_state", bus.present_state, 3'b000);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_ign_idle", {bus.present_state, bus.busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
